// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch (IFU) and load/store (LSU).
// Latency: accept at T, mem_req_valid at T+1, response pulse one cycle after mem_rsp_valid (min 3 cycles).
// Backpressure: one transaction in flight; requesters see ready only in IDLE, and REQ holds until mem_req_ready.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_EN   = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_rsp_err,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_rsp_err,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,

  output logic                busy,
  output logic                grant_lsu
);

  localparam int STRB_W = DATA_W / 8;

  // Owner encoding: the LSU is "1" so grant_lsu is simply the owner flop.
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  // Timer value seen in the last RESP cycle allowed before the error response.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_owner_q, last_owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [7:0]          timer_q, timer_d;

  logic                ifu_rsp_valid_q, ifu_rsp_valid_d;
  logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
  logic                ifu_rsp_err_q, ifu_rsp_err_d;
  logic                lsu_rsp_valid_q, lsu_rsp_valid_d;
  logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
  logic                lsu_rsp_err_q, lsu_rsp_err_d;

  logic                pick_lsu;
  logic                accept;
  logic                rsp_done;
  logic                rsp_err;
  logic [DATA_W-1:0]   rsp_data;

  // Arbitration: on a tie, round-robin against the last owner or fixed LSU priority.
  always_comb begin
    pick_lsu = lsu_req_valid;
    if (lsu_req_valid && ifu_req_valid) begin
      if (RR_EN != 0) begin
        pick_lsu = (last_owner_q == OWN_IFU);
      end else begin
        pick_lsu = 1'b1;
      end
    end
  end

  // Only the winner sees ready, and only while no transaction is in flight.
  assign ifu_req_ready = (state_q == ST_IDLE) && ifu_req_valid && !pick_lsu;
  assign lsu_req_ready = (state_q == ST_IDLE) && lsu_req_valid &&  pick_lsu;
  assign accept        = ifu_req_ready || lsu_req_ready;

  // Completion in RESP: a real response beats a timeout landing in the same cycle.
  always_comb begin
    rsp_done = 1'b0;
    rsp_err  = 1'b0;
    rsp_data = '0;
    if (state_q == ST_RESP) begin
      if (mem_rsp_valid) begin
        rsp_done = 1'b1;
        rsp_data = wen_q ? '0 : mem_rdata;
      end else if (timer_q == TMO_LAST) begin
        rsp_done = 1'b1;
        rsp_err  = 1'b1;
      end
    end
  end

  // Next-state, request capture, timer and response-pulse generation.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_owner_d    = last_owner_q;
    addr_d          = addr_q;
    wen_d           = wen_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    timer_d         = timer_q;
    ifu_rsp_valid_d = 1'b0;
    ifu_rdata_d     = '0;
    ifu_rsp_err_d   = 1'b0;
    lsu_rsp_valid_d = 1'b0;
    lsu_rdata_d     = '0;
    lsu_rsp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d      = pick_lsu ? OWN_LSU : OWN_IFU;
          last_owner_d = pick_lsu ? OWN_LSU : OWN_IFU;
          if (pick_lsu) begin
            addr_d  = lsu_addr;
            wen_d   = lsu_wen;
            wdata_d = lsu_wdata;
            wstrb_d = lsu_wstrb;
          end else begin
            // Fetches are always reads with no byte enables.
            addr_d  = ifu_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wstrb_d = '0;
          end
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        if (mem_req_ready) begin
          timer_d = '0;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        timer_d = timer_q + 8'd1;
        if (rsp_done) begin
          if (owner_q == OWN_LSU) begin
            lsu_rsp_valid_d = 1'b1;
            lsu_rdata_d     = rsp_data;
            lsu_rsp_err_d   = rsp_err;
          end else begin
            ifu_rsp_valid_d = 1'b1;
            ifu_rdata_d     = rsp_data;
            ifu_rsp_err_d   = rsp_err;
          end
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q         <= ST_IDLE;
      owner_q         <= 1'b0;
      last_owner_q    <= OWN_LSU;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      timer_q         <= '0;
      ifu_rsp_valid_q <= 1'b0;
      ifu_rdata_q     <= '0;
      ifu_rsp_err_q   <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
      lsu_rdata_q     <= '0;
      lsu_rsp_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_owner_q    <= last_owner_d;
      addr_q          <= addr_d;
      wen_q           <= wen_d;
      wdata_q         <= wdata_d;
      wstrb_q         <= wstrb_d;
      timer_q         <= timer_d;
      ifu_rsp_valid_q <= ifu_rsp_valid_d;
      ifu_rdata_q     <= ifu_rdata_d;
      ifu_rsp_err_q   <= ifu_rsp_err_d;
      lsu_rsp_valid_q <= lsu_rsp_valid_d;
      lsu_rdata_q     <= lsu_rdata_d;
      lsu_rsp_err_q   <= lsu_rsp_err_d;
    end
  end

  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;

  assign ifu_rsp_valid = ifu_rsp_valid_q;
  assign ifu_rdata     = ifu_rdata_q;
  assign ifu_rsp_err   = ifu_rsp_err_q;
  assign lsu_rsp_valid = lsu_rsp_valid_q;
  assign lsu_rdata     = lsu_rdata_q;
  assign lsu_rsp_err   = lsu_rsp_err_q;

  assign busy          = (state_q != ST_IDLE);
  assign grant_lsu     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: round-robin/timeout instance plus a fixed-priority instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// The fixed-priority instance talks to a memory that accepts at once and answers next cycle.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;

  // Instance A: RR_EN=1, TIMEOUT=4, memory driven by hand.
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_rsp_valid, lsu_rsp_err;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        busy, grant_lsu;

  // Instance B: RR_EN=0, auto-responding memory.
  logic        b_ifu_req_valid, b_ifu_req_ready;
  logic [31:0] b_ifu_addr;
  logic        b_ifu_rsp_valid, b_ifu_rsp_err;
  logic [31:0] b_ifu_rdata;
  logic        b_lsu_req_valid, b_lsu_req_ready, b_lsu_wen;
  logic [31:0] b_lsu_addr, b_lsu_wdata, b_lsu_rdata;
  logic [3:0]  b_lsu_wstrb;
  logic        b_lsu_rsp_valid, b_lsu_rsp_err;
  logic        b_mem_req_valid, b_mem_req_ready, b_mem_wen, b_mem_rsp_valid;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_wstrb;
  logic        b_busy, b_grant_lsu;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .busy(busy), .grant_lsu(grant_lsu)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(0), .TIMEOUT(4)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(b_ifu_req_valid), .ifu_req_ready(b_ifu_req_ready), .ifu_addr(b_ifu_addr),
    .ifu_rsp_valid(b_ifu_rsp_valid), .ifu_rdata(b_ifu_rdata), .ifu_rsp_err(b_ifu_rsp_err),
    .lsu_req_valid(b_lsu_req_valid), .lsu_req_ready(b_lsu_req_ready), .lsu_addr(b_lsu_addr),
    .lsu_wen(b_lsu_wen), .lsu_wdata(b_lsu_wdata), .lsu_wstrb(b_lsu_wstrb),
    .lsu_rsp_valid(b_lsu_rsp_valid), .lsu_rdata(b_lsu_rdata), .lsu_rsp_err(b_lsu_rsp_err),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready), .mem_addr(b_mem_addr),
    .mem_wen(b_mem_wen), .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb),
    .mem_rsp_valid(b_mem_rsp_valid), .mem_rdata(b_mem_rdata),
    .busy(b_busy), .grant_lsu(b_grant_lsu)
  );

  assign b_mem_req_ready = 1'b1;
  assign b_mem_rdata     = 32'h0000_0B0B;

  // Memory for instance B: accepts immediately, responds the following cycle.
  always @(posedge clk) begin
    if (rst_n) b_mem_rsp_valid <= 1'b0;
    else       b_mem_rsp_valid <= b_mem_req_valid;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, {ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid, lsu_rsp_err, mem_req_valid,
                        mem_wen, busy, grant_lsu, ifu_req_ready, lsu_req_ready}, '0);
    chk({tag, "_rdata"}, {ifu_rdata, lsu_rdata}, '0);
    chk({tag, "_memf"}, {mem_addr, mem_wdata, mem_wstrb}, '0);
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d);
    ifu_req_valid = 1'b1; ifu_addr = a; mem_req_ready = 1'b1;
    smp();
    chk("fetch_ready", {ifu_req_ready, lsu_req_ready}, 2'b10);
    cyc();
    ifu_req_valid = 1'b0;
    smp();
    chk("fetch_memreq", {mem_req_valid, mem_wen, mem_wstrb, mem_addr}, {1'b1, 1'b0, 4'h0, a});
    chk("fetch_busy", {busy, grant_lsu}, 2'b10);
    cyc();
    mem_rsp_valid = 1'b1; mem_rdata = d;
    smp();
    chk("fetch_wait", {mem_req_valid, ifu_rsp_valid}, 2'b00);
    cyc();
    mem_rsp_valid = 1'b0; mem_rdata = '0;
    smp();
    chk("fetch_rsp", {ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid, busy}, 4'b1000);
    chk("fetch_rdata", ifu_rdata, d);
    cyc();
    smp();
    chk("fetch_pulse_end", ifu_rsp_valid, 1'b0);
    cyc();
  endtask

  // Safety net in case a directed sequence stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] fp_order;
    int         fp_cnt;
    logic       fp_done, fp_both;

    rst_n = 1'b1;
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wstrb = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
    b_ifu_req_valid = 0; b_ifu_addr = 32'h9000_0000;
    b_lsu_req_valid = 0; b_lsu_addr = 32'h9000_1000; b_lsu_wen = 0;
    b_lsu_wdata = '0; b_lsu_wstrb = 4'hF;

    // Reset state
    do_reset();
    smp();
    check_all_zero("reset");
    cyc();

    // Single fetch, minimum turnaround
    do_fetch(32'h8000_0000, 32'h0010_0093);

    // Round-robin tie: IFU, LSU, IFU, LSU from reset
    do_reset();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0; lsu_wstrb = 4'hF;
    mem_req_ready = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        ifu_req_valid = 0; lsu_req_valid = 0;
      end
      smp();
      if (i > 0) begin
        chk("rr_rsp", {ifu_rsp_valid, lsu_rsp_valid}, ((i - 1) % 2 == 1) ? 2'b01 : 2'b10);
        chk("rr_rdata", ((i - 1) % 2 == 1) ? lsu_rdata : ifu_rdata, 32'h1000 + 32'(i - 1));
      end
      if (i == 4) break;
      chk("rr_grant", {ifu_req_ready, lsu_req_ready}, (i % 2 == 1) ? 2'b01 : 2'b10);
      cyc();
      smp();
      chk("rr_addr", mem_addr, (i % 2 == 1) ? 32'h8000_2000 : 32'h8000_0100);
      cyc();
      mem_rsp_valid = 1; mem_rdata = 32'h1000 + 32'(i);
      cyc();
      mem_rsp_valid = 0; mem_rdata = '0;
    end
    cyc();

    // Fixed priority: LSU, LSU, then IFU once LSU drops
    fp_order = '0; fp_cnt = 0; fp_done = 0; fp_both = 0;
    b_ifu_req_valid = 1; b_lsu_req_valid = 1;
    for (int c = 0; c < 60 && !fp_done; c++) begin
      smp();
      if (b_ifu_req_ready && b_lsu_req_ready) fp_both = 1;
      if (b_lsu_req_ready) begin
        fp_order = {fp_order[1:0], 1'b1}; fp_cnt++;
      end else if (b_ifu_req_ready) begin
        fp_order = {fp_order[1:0], 1'b0}; fp_cnt++; fp_done = 1;
      end
      cyc();
      if (fp_cnt == 2) b_lsu_req_valid = 0;
      if (fp_done) b_ifu_req_valid = 0;
    end
    chk("fp_finished", fp_done, 1'b1);
    chk("fp_both_ready", fp_both, 1'b0);
    chk("fp_count", 32'(fp_cnt), 32'd3);
    chk("fp_order", fp_order, 3'b110);
    cyc();
    cyc();
    smp();
    chk("fp_ifu_rsp", {b_ifu_rsp_valid, b_ifu_rdata}, {1'b1, 32'h0000_0B0B});
    chk("fp_misc", {b_ifu_rsp_err, b_lsu_rsp_valid, b_lsu_rsp_err, b_lsu_rdata, b_busy,
                    b_grant_lsu, b_mem_req_valid, b_mem_wen, b_mem_wstrb, b_mem_addr, b_mem_wdata},
        {1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h9000_0000, 32'h0});
    cyc();

    // LSU store with memory stalling the request for 3 cycles
    lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF; mem_req_ready = 0;
    smp();
    chk("st_ready", {ifu_req_ready, lsu_req_ready}, 2'b01);
    cyc();
    lsu_req_valid = 0; lsu_wdata = '0; lsu_addr = '0; lsu_wstrb = '0;
    for (int k = 0; k < 4; k++) begin
      mem_req_ready = (k == 3);
      smp();
      chk("st_hold", {mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb},
          {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF});
      cyc();
    end
    mem_rsp_valid = 1; mem_rdata = 32'h1234_5678;
    smp();
    chk("st_wait", {mem_req_valid, lsu_rsp_valid, busy}, 3'b001);
    cyc();
    mem_rsp_valid = 0;
    smp();
    chk("st_rsp", {lsu_rsp_valid, lsu_rsp_err, ifu_rsp_valid, grant_lsu}, 4'b1001);
    chk("st_rdata", lsu_rdata, 32'h0);
    cyc();

    // Timeout: memory never answers, TIMEOUT=4
    lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_3000; mem_req_ready = 1;
    mem_rdata = 32'h1111_1111;
    smp();
    chk("tmo_ready", lsu_req_ready, 1'b1);
    cyc();
    lsu_req_valid = 0;
    cyc();
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("tmo_wait", {lsu_rsp_valid, ifu_rsp_valid, busy}, 3'b001);
      cyc();
    end
    smp();
    chk("tmo_rsp", {lsu_rsp_valid, lsu_rsp_err, busy, ifu_rsp_valid}, 4'b1100);
    chk("tmo_rdata", lsu_rdata, 32'h0);
    cyc();
    smp();
    chk("tmo_once", {lsu_rsp_valid, busy}, 2'b00);
    cyc();
    mem_rsp_valid = 1; mem_rdata = 32'hAAAA_5555;
    cyc();
    mem_rsp_valid = 0;
    smp();
    chk("stray_idle", {lsu_rsp_valid, ifu_rsp_valid, busy}, 3'b000);
    cyc();

    // Boundary: response in the same cycle the timer reaches TIMEOUT
    lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_4000; mem_req_ready = 1;
    smp();
    chk("bnd_ready", lsu_req_ready, 1'b1);
    cyc();
    lsu_req_valid = 0;
    cyc();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        mem_rsp_valid = 1; mem_rdata = 32'hCAFE_F00D;
      end
      smp();
      chk("bnd_wait", lsu_rsp_valid, 1'b0);
      cyc();
    end
    mem_rsp_valid = 0; mem_rdata = '0;
    smp();
    chk("bnd_rsp", {lsu_rsp_valid, lsu_rsp_err, ifu_rsp_valid}, 3'b100);
    chk("bnd_rdata", lsu_rdata, 32'hCAFE_F00D);
    cyc();
    smp();
    chk("bnd_once", lsu_rsp_valid, 1'b0);
    cyc();

    // Reset while in RESP, then a late memory response
    ifu_req_valid = 1; ifu_addr = 32'h8000_0010; mem_req_ready = 1;
    cyc();
    ifu_req_valid = 0;
    cyc();
    rst_n = 1'b1;
    cyc();
    rst_n = 1'b0; mem_rsp_valid = 1; mem_rdata = 32'h0000_0055;
    smp();
    check_all_zero("rst_resp");
    cyc();
    mem_rsp_valid = 0; mem_rdata = '0;
    smp();
    chk("rst_no_rsp", {ifu_rsp_valid, lsu_rsp_valid, busy}, 3'b000);
    cyc();
    do_fetch(32'h8000_0020, 32'h0020_0113);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
